ptw_responder: RTL
==================

# ptw_responder

Page-table-walk responder serving two TLB clients (instruction and data) over the `ptw_resp` channel (`valid`/`error`/`ppn`) that the TLB blocks consume. It accepts one translation request at a time, arbitrates round-robin between clients, walks a two-level page table through a single-outstanding memory port, and returns a one-cycle response pulse to the requesting client only.

## Interface
- `VPN_W`, 20: virtual page number width; split as level-0 index `vpn[19:10]` and level-1 index `vpn[9:0]`
- `PPN_W`, 32: response PPN width; the 22-bit PTE PPN field is zero-extended to this width
- `PADDR_W`, 34: memory address width, formed as `{base_ppn[21:0], index[9:0], 2'b00}`
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `ptbr`  in  22  root table PPN; sampled when a request is accepted
- `io_imem_req_valid` / `io_dmem_req_valid`  in  1  client request valid
- `io_imem_req_ready` / `io_dmem_req_ready`  out  1  accept strobe for that client
- `io_imem_req_bits_vpn` / `io_dmem_req_bits_vpn`  in  VPN_W  VPN to translate
- `io_imem_resp_valid` / `io_dmem_resp_valid`  out  1  one-cycle response pulse
- `io_imem_resp_bits_error` / `io_dmem_resp_bits_error`  out  1  walk fault
- `io_imem_resp_bits_ppn` / `io_dmem_resp_bits_ppn`  out  PPN_W  translated PPN
- `mem_req_valid`  out  1  PTE read request
- `mem_req_ready`  in  1  memory accepts the request
- `mem_req_addr`  out  PADDR_W  PTE address
- `mem_resp_valid`  in  1  PTE data valid
- `mem_resp_data`  in  32  PTE: `[0]` V, `[1]` leaf, `[31:10]` PPN

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Grant goes to a single valid client. When both are valid, grant goes to the client not served last. Last-served resets to dmem, so imem wins the first tie.
  - `req_ready` is asserted only to the granted client, combinationally, only in IDLE.
  - On handshake, latch vpn, client id, `ptbr` as base, and level=0, then go to REQ.
- REQ:
  - `mem_req_valid`=1 with `mem_req_addr = {base, idx(level), 2'b00}`.
  - Stay in REQ until `mem_req_ready`, then go to WAIT.
- WAIT:
  - `mem_resp_valid` decides the next step:
  - V=0: error=1, ppn=0, go to DONE.
  - V=1, leaf=0, level 0: base ← PTE PPN, level ← 1, go to REQ.
  - V=1, leaf=0, level 1: error=1, ppn=0, go to DONE.
  - V=1, leaf=1, level 1: error=0, ppn=zext(PTE PPN), go to DONE.
  - V=1, leaf=1, level 0: superpage, handled per Configuration.
- DONE: pulse `resp_valid` for the latched client only, update last-served, return to IDLE.
- `mem_resp_valid` outside WAIT is ignored.
- `resp_bits_*` hold their last value between pulses. The `resp_bits_*` of the other client are unaffected.

## Timing
- Reset values:
  - State IDLE, `mem_req_valid`=0.
  - Both `resp_valid`=0, `resp_bits_error`=0, `resp_bits_ppn`=0.
  - `req_ready` follows the grant, which is combinational.
- Reset mid-walk aborts the walk. No response is issued and the memory response is dropped.
- Latency with zero-wait memory (`mem_req_ready` and `mem_resp_valid` in the cycle after the request):
  - Accept at cycle 0, REQ at cycle 1, WAIT at cycle 2, `resp_valid` at cycle 3 for a level-0 outcome.
  - A two-level walk responds at cycle 5.
- Back-to-back: the next request can be accepted in the cycle after the DONE pulse (the cycle the block is back in IDLE).
- `mem_req_addr` is stable while `mem_req_valid`=1.

## Configuration
- `PTW_SUPERPAGE_EN`:
  - Defined: a leaf at level 0 returns error=0 and ppn=zext({PTE_PPN[21:10], vpn[9:0]}). It returns error=1 if `PTE_PPN[9:0]`≠0 (misaligned superpage).
  - Undefined: any leaf at level 0 returns error=1, ppn=0.

## Test plan
- Single-level path:
  - Stimulus: imem vpn=0x00401, ptbr=0x1. PTE at 0x1004 (level 0) = 0x00000C03, leaf, PPN=0x3.
  - Required response: with `PTW_SUPERPAGE_EN` undefined, imem resp error=1 at cycle 3.
  - Repeat with `PTW_SUPERPAGE_EN` defined: misaligned, so error=1.
  - Repeat with PTE 0x00100003: ppn=0x401, error=0.
- Two-level walk:
  - Stimulus: dmem vpn=0x00802, ptbr=0x1. L0 PTE = 0x00000801 (PPN 0x2). L1 at addr 0x2008 = 0x12345403.
  - Required response: dmem resp ppn=0x0004_8D15, error=0 at cycle 5. imem resp_valid stays 0.
- Invalid PTE:
  - Stimulus: L0 PTE=0x0.
  - Required response: error=1, ppn=0, exactly one resp_valid pulse.
- Arbitration:
  - Stimulus: both clients valid continuously after reset.
  - Required response: grants alternate imem, dmem, imem. Each resp goes only to its own client.
- Backpressure and reset:
  - Stimulus: hold `mem_req_ready`=0 for 4 cycles. Then assert reset while in WAIT.
  - Required response: addr stable throughout the stall. After reset, state is IDLE, no resp pulse, and the late `mem_resp_valid` is ignored.

Source files
------------

// File: rtl/ptw_responder.sv
// Two-client, two-level page-table walker with round-robin arbitration.
// Optional superpage leaves at level 0 enabled by PTW_SUPERPAGE_EN.
module ptw_responder #(
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 32,
  parameter int PADDR_W = 34
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [21:0]        ptbr,
  input  logic               io_imem_req_valid,
  output logic               io_imem_req_ready,
  input  logic [VPN_W-1:0]   io_imem_req_bits_vpn,
  output logic               io_imem_resp_valid,
  output logic               io_imem_resp_bits_error,
  output logic [PPN_W-1:0]   io_imem_resp_bits_ppn,
  input  logic               io_dmem_req_valid,
  output logic               io_dmem_req_ready,
  input  logic [VPN_W-1:0]   io_dmem_req_bits_vpn,
  output logic               io_dmem_resp_valid,
  output logic               io_dmem_resp_bits_error,
  output logic [PPN_W-1:0]   io_dmem_resp_bits_ppn,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [PADDR_W-1:0] mem_req_addr,
  input  logic               mem_resp_valid,
  input  logic [31:0]        mem_resp_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [VPN_W-1:0] r_vpn;
  logic             r_client;
  logic [21:0]      r_base;
  logic             r_level;
  logic             r_last_dmem;
  logic             r_mem_req_valid;

  logic             r_imem_valid;
  logic             r_imem_err;
  logic [PPN_W-1:0] r_imem_ppn;
  logic             r_dmem_valid;
  logic             r_dmem_err;
  logic [PPN_W-1:0] r_dmem_ppn;

  logic             w_idle;
  logic             w_grant_imem;
  logic             w_grant_dmem;
  logic             w_fire;
  logic [9:0]       w_idx;
  logic             w_pte_v;
  logic             w_pte_leaf;
  logic [21:0]      w_pte_ppn;
  logic             w_super_err;
  logic [21:0]      w_super_ppn;
  logic             w_done;
  logic             w_err;
  logic [21:0]      w_ppn;
  logic             w_unused;

  assign w_idle = (r_state == S_IDLE);

  // imem wins unless dmem also asks and imem was served last
  assign w_grant_imem = io_imem_req_valid &&
                        (!io_dmem_req_valid || r_last_dmem);
  assign w_grant_dmem = io_dmem_req_valid && !w_grant_imem;
  assign w_fire       = w_idle && (w_grant_imem || w_grant_dmem);

  assign io_imem_req_ready = w_idle && w_grant_imem;
  assign io_dmem_req_ready = w_idle && w_grant_dmem;

  assign w_idx = r_level ? r_vpn[9:0] : r_vpn[19:10];

  // Address derives only from state that is frozen during REQ
  assign mem_req_addr  = PADDR_W'({r_base, w_idx, 2'b00});
  assign mem_req_valid = r_mem_req_valid;

  assign w_pte_v    = mem_resp_data[0];
  assign w_pte_leaf = mem_resp_data[1];
  assign w_pte_ppn  = mem_resp_data[31:10];
  assign w_unused   = ^mem_resp_data[9:2];

`ifdef PTW_SUPERPAGE_EN
  assign w_super_err = |w_pte_ppn[9:0];
  assign w_super_ppn = {w_pte_ppn[21:10], r_vpn[9:0]};
`else
  assign w_super_err = 1'b1;
  assign w_super_ppn = '0;
`endif

  // Classify the returned PTE: descend, fault, or translate
  always_comb begin
    w_done = 1'b1;
    w_err  = 1'b1;
    w_ppn  = '0;
    if (!w_pte_v) begin
      w_err = 1'b1;
    end else if (!w_pte_leaf && !r_level) begin
      w_done = 1'b0;
    end else if (!w_pte_leaf) begin
      w_err = 1'b1;
    end else if (r_level) begin
      w_err = 1'b0;
      w_ppn = w_pte_ppn;
    end else begin
      w_err = w_super_err;
      w_ppn = w_super_err ? '0 : w_super_ppn;
    end
  end

  // Walk FSM with registered memory request and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_vpn           <= '0;
      r_client        <= 1'b0;
      r_base          <= '0;
      r_level         <= 1'b0;
      r_last_dmem     <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_imem_valid    <= 1'b0;
      r_imem_err      <= 1'b0;
      r_imem_ppn      <= '0;
      r_dmem_valid    <= 1'b0;
      r_dmem_err      <= 1'b0;
      r_dmem_ppn      <= '0;
    end else begin
      r_imem_valid <= 1'b0;
      r_dmem_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_vpn           <= w_grant_imem ? io_imem_req_bits_vpn
                                            : io_dmem_req_bits_vpn;
            r_client        <= w_grant_dmem;
            r_base          <= ptbr;
            r_level         <= 1'b0;
            r_mem_req_valid <= 1'b1;
            r_state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            if (!w_done) begin
              r_base          <= w_pte_ppn;
              r_level         <= 1'b1;
              r_mem_req_valid <= 1'b1;
              r_state         <= S_REQ;
            end else begin
              r_state <= S_DONE;
              if (r_client) begin
                r_dmem_valid <= 1'b1;
                r_dmem_err   <= w_err;
                r_dmem_ppn   <= PPN_W'(w_ppn);
              end else begin
                r_imem_valid <= 1'b1;
                r_imem_err   <= w_err;
                r_imem_ppn   <= PPN_W'(w_ppn);
              end
            end
          end
        end
        S_DONE: begin
          r_last_dmem <= r_client;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_imem_resp_valid      = r_imem_valid;
  assign io_imem_resp_bits_error = r_imem_err;
  assign io_imem_resp_bits_ppn   = r_imem_ppn;
  assign io_dmem_resp_valid      = r_dmem_valid;
  assign io_dmem_resp_bits_error = r_dmem_err;
  assign io_dmem_resp_bits_ppn   = r_dmem_ppn;

endmodule
